// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Push-button front-end and run/pause/lap controller for the
//             stopwatch counter_n chain. Each raw key is synchronised,
//             debounced and turned into a one-cycle rising-edge pulse. The
//             pulses drive a four-state FSM, which generates the chain enable,
//             the chain reset and the display hold flag.
//  Ports    : clk      - system clock, rising edge
//             r        - synchronous active-high reset
//             tick     - one-cycle base-rate enable from the prescaler
//             key_ss   - raw start/stop button (asynchronous)
//             key_clr  - raw clear button (asynchronous)
//             key_lap  - raw lap button (asynchronous)
//             cnt_en   - enable to the first counter_n stage
//             cnt_r    - synchronous reset to all counter_n stages
//             hold     - display latches frozen while in LAP
//             state    - FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
   parameter int DEB_N    = 20,
   parameter int DEB_BITS = 5
) (
   input  logic       clk,
   input  logic       r,
   input  logic       tick,
   input  logic       key_ss,
   input  logic       key_clr,
   input  logic       key_lap,
   output logic       cnt_en,
   output logic       cnt_r,
   output logic       hold,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   localparam logic [DEB_BITS-1:0] c_deb_last = DEB_BITS'(DEB_N - 1);
   localparam logic [DEB_BITS-1:0] c_deb_one  = DEB_BITS'(1);

   // Index 0 = start/stop, 1 = clear, 2 = lap
   logic [2:0] w_key_raw;
   logic [2:0] w_key_p;

   assign w_key_raw = {key_lap, key_clr, key_ss};

   // -------------------------------------------------------------------------
   // Per-key synchroniser, debouncer and rising-edge pulse generator
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_key
         logic                r_sync1;
         logic                r_sync2;
         logic                r_deb;
         logic                r_deb_d;
         logic                r_pulse;
         logic [DEB_BITS-1:0] r_cnt;

         always_ff @(posedge clk) begin
            if (r) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_deb   <= 1'b0;
               r_deb_d <= 1'b0;
               r_pulse <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_key_raw[gi];
               r_sync2 <= r_sync1;
               // The counter tracks how many consecutive cycles the
               // synchronised level has disagreed with the accepted level.
               // The level is accepted on the DEB_N-th disagreeing cycle.
               if (r_sync2 == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_deb_last) begin
                  r_deb <= r_sync2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_deb_one;
               end
               // Edge detect on the accepted level, one cycle after it rises
               r_deb_d <= r_deb;
               r_pulse <= r_deb & ~r_deb_d;
            end
         end

         assign w_key_p[gi] = r_pulse;
      end
   endgenerate

   logic w_ss_p;
   logic w_clr_p;
   logic w_lap_p;

   assign w_ss_p  = w_key_p[0];
   assign w_clr_p = w_key_p[1];
   assign w_lap_p = w_key_p[2];

   // -------------------------------------------------------------------------
   // Control FSM with registered hold / chain reset
   // -------------------------------------------------------------------------
   state_t r_state;
   logic   r_hold;
   logic   r_cnt_r;
   logic   r_rst_d;   // stretches cnt_r over the first cycle after reset

   always_ff @(posedge clk) begin
      if (r) begin
         r_state <= ST_IDLE;
         r_hold  <= 1'b0;
         r_cnt_r <= 1'b1;
         r_rst_d <= 1'b1;
      end else begin
         r_rst_d <= 1'b0;
         r_cnt_r <= r_rst_d;
         case (r_state)
            ST_IDLE: begin
               if (w_ss_p) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_ss_p) begin
                  r_state <= ST_PAUSE;
               end else if (w_lap_p) begin
                  r_state <= ST_LAP;
                  r_hold  <= 1'b1;
               end
            end
            ST_LAP: begin
               if (w_ss_p) begin
                  r_state <= ST_PAUSE;
                  r_hold  <= 1'b0;
               end else if (w_lap_p) begin
                  r_state <= ST_RUN;
                  r_hold  <= 1'b0;
               end
            end
            ST_PAUSE: begin
               // Clear wins over a simultaneous start/stop
               if (w_clr_p) begin
                  r_state <= ST_IDLE;
                  r_cnt_r <= 1'b1;
               end else if (w_ss_p) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hold  <= 1'b0;
            end
         endcase
      end
   end

   // Enable is combinational from the registered state so a tick arriving
   // in a RUN/LAP cycle reaches the counter in that same cycle.
   assign cnt_en = tick & ((r_state == ST_RUN) || (r_state == ST_LAP));
   assign cnt_r  = r_cnt_r;
   assign hold   = r_hold;
   assign state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Directed self-checking bench for stopwatch_ctrl with DEB_N=4.
//             Inputs change 1 time unit after a rising edge; outputs are
//             compared 1-2 time units after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

   localparam int c_deb_n    = 4;
   localparam int c_deb_bits = 3;
   localparam int c_lat      = c_deb_n + 3;   // raw edge to pulse, cycles

   logic       clk;
   logic       r;
   logic       tick;
   logic       key_ss;
   logic       key_clr;
   logic       key_lap;
   logic       cnt_en;
   logic       cnt_r;
   logic       hold;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   stopwatch_ctrl #(
      .DEB_N    (c_deb_n),
      .DEB_BITS (c_deb_bits)
   ) dut (
      .clk     (clk),
      .r       (r),
      .tick    (tick),
      .key_ss  (key_ss),
      .key_clr (key_clr),
      .key_lap (key_lap),
      .cnt_en  (cnt_en),
      .cnt_r   (cnt_r),
      .hold    (hold),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0:       key_ss  = v;
         1:       key_clr = v;
         default: key_lap = v;
      endcase
   endtask

   // Press long enough to register, then release and let the release settle
   task automatic press(input int k);
      set_key(k, 1'b1);
      repeat (c_lat + 1) step();
      set_key(k, 1'b0);
      repeat (c_lat + 1) step();
   endtask

   // Pulse tick mid-cycle and compare the combinational enable
   task automatic tick_chk(input string tag, input logic exp_en);
      tick = 1'b1;
      #1;
      check(tag, {3'b0, cnt_en}, {3'b0, exp_en});
      tick = 1'b0;
      #1;
   endtask

   initial begin
      r       = 1'b1;
      tick    = 1'b0;
      key_ss  = 1'b0;
      key_clr = 1'b0;
      key_lap = 1'b0;

      // 1: reset for three cycles, then release
      repeat (3) step();
      check("rst_cnt_r", {3'b0, cnt_r}, 4'h1);
      check("rst_state", {2'b0, state}, 4'h0);
      check("rst_hold",  {3'b0, hold},  4'h0);
      tick_chk("rst_en", 1'b0);
      r = 1'b0;
      step();
      check("post_rst_cnt_r1", {3'b0, cnt_r}, 4'h1);
      step();
      check("post_rst_cnt_r0", {3'b0, cnt_r}, 4'h0);
      check("post_rst_state",  {2'b0, state}, 4'h0);

      // 2: clean start/stop press, exact latency, then enable follows tick
      key_ss = 1'b1;
      repeat (c_lat) step();
      check("ss_lat_idle", {2'b0, state}, 4'h0);
      step();
      check("ss_lat_run", {2'b0, state}, 4'h1);
      for (int i = 0; i < 10; i++) begin
         tick = (i % 5 == 0);
         #1;
         check("run_en_follow", {3'b0, cnt_en}, {3'b0, (i % 5 == 0)});
         tick = 1'b0;
         step();
      end
      key_ss = 1'b0;
      repeat (10) step();
      check("release_no_pulse", {2'b0, state}, 4'h1);

      // 3: glitches shorter than DEB_N never register
      for (int g = 0; g < 3; g++) begin
         key_ss = 1'b1;
         repeat (3) step();
         key_ss = 1'b0;
         repeat (5) step();
      end
      repeat (8) step();
      check("glitch_state", {2'b0, state}, 4'h1);
      tick_chk("glitch_en", 1'b1);

      // 4: lap in and out, then lap followed by start/stop
      press(2);
      check("lap_state", {2'b0, state}, 4'h3);
      check("lap_hold",  {3'b0, hold},  4'h1);
      tick_chk("lap_en", 1'b1);
      press(2);
      check("unlap_state", {2'b0, state}, 4'h1);
      check("unlap_hold",  {3'b0, hold},  4'h0);
      press(2);
      check("lap2_state", {2'b0, state}, 4'h3);
      press(0);
      check("lap_pause_state", {2'b0, state}, 4'h2);
      check("lap_pause_hold",  {3'b0, hold},  4'h0);
      tick_chk("pause_en", 1'b0);
      check("pause_cnt_r", {3'b0, cnt_r}, 4'h0);

      // 5: clear and start/stop together from PAUSE, clear wins
      key_clr = 1'b1;
      key_ss  = 1'b1;
      repeat (c_lat) step();
      check("clr_pre_state", {2'b0, state}, 4'h2);
      check("clr_pre_cnt_r", {3'b0, cnt_r}, 4'h0);
      step();
      check("clr_state", {2'b0, state}, 4'h0);
      check("clr_cnt_r", {3'b0, cnt_r}, 4'h1);
      step();
      check("clr_cnt_r_drop", {3'b0, cnt_r}, 4'h0);
      check("clr_no_run",     {2'b0, state}, 4'h0);
      key_clr = 1'b0;
      key_ss  = 1'b0;
      repeat (c_lat + 1) step();
      check("clr_settle", {2'b0, state}, 4'h0);

      // 6: reset while in LAP with lap key mid-debounce
      press(0);
      press(2);
      check("pre_rst_lap", {2'b0, state}, 4'h3);
      key_lap = 1'b1;
      repeat (3) step();
      r = 1'b1;
      step();
      r = 1'b0;
      check("mid_rst_state", {2'b0, state}, 4'h0);
      check("mid_rst_hold",  {3'b0, hold},  4'h0);
      check("mid_rst_cnt_r", {3'b0, cnt_r}, 4'h1);
      step();
      check("mid_rst_cnt_r_next", {3'b0, cnt_r}, 4'h1);
      step();
      check("mid_rst_cnt_r_drop", {3'b0, cnt_r}, 4'h0);
      key_lap = 1'b0;
      repeat (c_lat + 1) step();
      check("mid_rst_idle", {2'b0, state}, 4'h0);

      // 7: start/stop held through reset is re-qualified with full latency
      key_ss = 1'b1;
      repeat (c_lat + 1) step();
      check("held_run", {2'b0, state}, 4'h1);
      r = 1'b1;
      step();
      r = 1'b0;
      check("held_rst_idle", {2'b0, state}, 4'h0);
      repeat (c_lat) step();
      check("requal_wait", {2'b0, state}, 4'h0);
      step();
      check("requal_run", {2'b0, state}, 4'h1);
      key_ss = 1'b0;
      repeat (c_lat + 1) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
